ifu_fetch_queue: RTL

Fetch-group queue between the IFU/ICache response path and decode. Buffers up to `Cfg.IFU_FQ_DEPTH` fetch groups, each holding `Cfg.INSTR_PER_FETCH` instruction slots plus the BPU prediction. An optional empty-queue bypass is enabled by `Cfg.IFU_FETCHQ_BYPASS_EN`. Supports a single-cycle flush on redirect.

---
 rtl/config_pkg.sv | 29 ++
 rtl/frontend_pkg.sv | 17 +
 rtl/ifu_fq_mem.sv | 23 ++
 rtl/ifu_fetch_queue.sv | 118 +++++++++++
 4 files changed

// File: rtl/config_pkg.sv
// Global frontend configuration plus width helpers shared by IFU, the fetch queue and decode.
package config_pkg;

    typedef struct packed {
        int unsigned IFU_FQ_DEPTH;
        int unsigned INSTR_PER_FETCH;
        int unsigned ILEN;
        int unsigned VLEN;
        bit          IFU_FETCHQ_BYPASS_EN;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{
        IFU_FQ_DEPTH:         4,
        INSTR_PER_FETCH:      4,
        ILEN:                 32,
        VLEN:                 32,
        IFU_FETCHQ_BYPASS_EN: 1'b0
    };

    // A depth of 1 would give a zero-width pointer; keep at least one bit.
    function automatic int unsigned IFU_FQ_PTR_W(input cfg_t c);
        return (c.IFU_FQ_DEPTH > 1) ? $clog2(c.IFU_FQ_DEPTH) : 1;
    endfunction

    function automatic int unsigned IFU_FQ_CNT_W(input cfg_t c);
        return $clog2(c.IFU_FQ_DEPTH + 1);
    endfunction

endpackage

// File: rtl/frontend_pkg.sv
// Fetch-group record exchanged between IFU and decode, sized from the global config.
package frontend_pkg;
    import config_pkg::*;

    localparam int unsigned FE_IPF  = EmptyCfg.INSTR_PER_FETCH;
    localparam int unsigned FE_ILEN = EmptyCfg.ILEN;
    localparam int unsigned FE_VLEN = EmptyCfg.VLEN;

    typedef struct packed {
        logic [FE_VLEN-1:0]        pc;
        logic [FE_IPF*FE_ILEN-1:0] instr;
        logic [FE_IPF-1:0]         slot_valid;
        logic                      pred_taken;
        logic [FE_VLEN-1:0]        pred_target;
    } fetch_group_t;

endpackage

// File: rtl/ifu_fq_mem.sv
// Fetch-queue storage: one write port, one asynchronous read port, no reset.
module ifu_fq_mem #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  logic [W-1:0]     wdata_i,
    input  logic [PTR_W-1:0] raddr_i,
    output logic [W-1:0]     rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ifu_fetch_queue.sv
// Fetch-group queue between ICache response and decode, with optional empty-queue bypass
// and single-cycle flush on redirect.
module ifu_fetch_queue
    import config_pkg::*;
#(
    parameter cfg_t Cfg = EmptyCfg,
    localparam int unsigned IPF   = Cfg.INSTR_PER_FETCH,
    localparam int unsigned ILEN  = Cfg.ILEN,
    localparam int unsigned VLEN  = Cfg.VLEN,
    localparam int unsigned CNT_W = IFU_FQ_CNT_W(Cfg)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                enq_valid_i,
    output logic                enq_ready_o,
    input  logic [VLEN-1:0]     enq_pc_i,
    input  logic [IPF*ILEN-1:0] enq_instr_i,
    input  logic [IPF-1:0]      enq_slot_valid_i,
    input  logic                enq_pred_taken_i,
    input  logic [VLEN-1:0]     enq_pred_target_i,
    output logic                deq_valid_o,
    input  logic                deq_ready_i,
    output logic [VLEN-1:0]     deq_pc_o,
    output logic [IPF*ILEN-1:0] deq_instr_o,
    output logic [IPF-1:0]      deq_slot_valid_o,
    output logic                deq_pred_taken_o,
    output logic [VLEN-1:0]     deq_pred_target_o,
    output logic [CNT_W-1:0]    count_o
);

    localparam int unsigned DEPTH  = Cfg.IFU_FQ_DEPTH;
    localparam int unsigned PTR_W  = IFU_FQ_PTR_W(Cfg);
    localparam bit          BYPASS = Cfg.IFU_FETCHQ_BYPASS_EN;

    typedef struct packed {
        logic [VLEN-1:0]     pc;
        logic [IPF*ILEN-1:0] instr;
        logic [IPF-1:0]      slot_valid;
        logic                pred_taken;
        logic [VLEN-1:0]     pred_target;
    } grp_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic             full, empty, active;
    logic             bypass, enq_fire, deq_fire, push, pop;
    grp_t             enq_grp, rd_grp, deq_grp;

    assign enq_grp = '{
        pc:          enq_pc_i,
        instr:       enq_instr_i,
        slot_valid:  enq_slot_valid_i,
        pred_taken:  enq_pred_taken_i,
        pred_target: enq_pred_target_i
    };

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign active = rst_ni && !flush_i;

    // Ready looks only at registered full, never at deq_ready_i.
    assign enq_ready_o = active && !full;
    assign bypass      = BYPASS && active && empty && enq_valid_i;
    assign deq_valid_o = active && (!empty || bypass);

    assign enq_fire = enq_valid_i && enq_ready_o;
    assign deq_fire = deq_valid_o && deq_ready_i;
    // A bypassed group that decode takes the same cycle never touches storage.
    assign push     = enq_fire && !(bypass && deq_ready_i);
    assign pop      = deq_fire && !empty;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= ptr_inc(tail_q);
            if (pop)  head_q <= ptr_inc(head_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    ifu_fq_mem #(
        .DEPTH (DEPTH),
        .W     ($bits(grp_t)),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (push),
        .waddr_i (tail_q),
        .wdata_i (enq_grp),
        .raddr_i (head_q),
        .rdata_o (rd_grp)
    );

    always_comb begin
        deq_grp = '0;
        if (deq_valid_o) deq_grp = empty ? enq_grp : rd_grp;
    end

    assign deq_pc_o          = deq_grp.pc;
    assign deq_instr_o       = deq_grp.instr;
    assign deq_slot_valid_o  = deq_grp.slot_valid;
    assign deq_pred_taken_o  = deq_grp.pred_taken;
    assign deq_pred_target_o = deq_grp.pred_target;
    assign count_o           = count_q;

endmodule
